// File: rtl/alu_shift_pkg.sv
// Shared encodings for the 8088 shift/rotate sequencer: opcodes, flag bit
// positions and controller state codes.
package alu_shift_pkg;

    localparam logic [2:0] OP_SHL = 3'b000;
    localparam logic [2:0] OP_SHR = 3'b001;
    localparam logic [2:0] OP_SAR = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    localparam int F_CF = 0;
    localparam int F_PF = 1;
    localparam int F_ZF = 2;
    localparam int F_SF = 3;
    localparam int F_OF = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [4:0] MASK_ALL    = 5'h1F;
    localparam logic [4:0] MASK_ROTATE = 5'h11;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= OP_ROR;
    endfunction

endpackage

// File: rtl/alu_shift_sequencer_shift_step_16.sv
// Combinational barrel stage: shifts or rotates a byte/word operand by 0..8
// positions and reports the last bit moved out.
module shift_step_16
    import alu_shift_pkg::*;
(
    input  logic [15:0] acc,
    input  logic [3:0]  k,
    input  logic [2:0]  op,
    input  logic        is_byte,
    output logic [15:0] res,
    output logic        cout
);

    // Each operand sits in a widened vector so the bit shifted out last lands
    // at a fixed position, whatever k is.
    logic [15:0]        b_left;
    logic [15:0]        b_right;
    logic signed [15:0] b_signed;
    logic [15:0]        b_rot_l;
    logic [15:0]        b_rot_r;
    logic [31:0]        w_left;
    logic [31:0]        w_right;
    logic signed [31:0] w_signed;
    logic [31:0]        w_rot_l;
    logic [31:0]        w_rot_r;

    always_comb begin
        b_signed = {acc[7:0], 8'h00};
        w_signed = {acc, 16'h0000};
        b_left   = {8'h00, acc[7:0]} << k;
        w_left   = {16'h0000, acc} << k;
        b_rot_l  = {acc[7:0], acc[7:0]} << k;
        b_rot_r  = {acc[7:0], acc[7:0]} >> k;
        w_rot_l  = {acc, acc} << k;
        w_rot_r  = {acc, acc} >> k;
        if (op == OP_SAR) begin
            b_right = b_signed >>> k;
            w_right = w_signed >>> k;
        end else begin
            b_right = {acc[7:0], 8'h00} >> k;
            w_right = {acc, 16'h0000} >> k;
        end
    end

    always_comb begin
        // NOTE: default every output first so no path leaves one unassigned and infers a latch.
        res  = acc;
        cout = 1'b0;
        if (is_byte) begin
            case (op)
                OP_SHL: begin res = {8'h00, b_left[7:0]};   cout = b_left[8];  end
                OP_SHR,
                OP_SAR: begin res = {8'h00, b_right[15:8]}; cout = b_right[7]; end
                OP_ROL: begin res = {8'h00, b_rot_l[15:8]}; cout = b_rot_l[8]; end
                OP_ROR: begin res = {8'h00, b_rot_r[7:0]};  cout = b_rot_r[7]; end
                default: ;
            endcase
        end else begin
            case (op)
                OP_SHL: begin res = w_left[15:0];   cout = w_left[16];  end
                OP_SHR,
                OP_SAR: begin res = w_right[31:16]; cout = w_right[15]; end
                OP_ROL: begin res = w_rot_l[31:16]; cout = w_rot_l[16]; end
                OP_ROR: begin res = w_rot_r[15:0];  cout = w_rot_r[15]; end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu_shift_sequencer.sv
// Multi-cycle 8088 shift/rotate controller: steps an operand through the
// barrel stage at most STEP_MAX bits per cycle, then presents result and flags.
module alu_shift_sequencer
    import alu_shift_pkg::*;
#(
    parameter int STEP_MAX = 8,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             is_byte,
    input  logic [15:0]      a,
    input  logic [CNT_W-1:0] count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      r,
    output logic [4:0]       flags,
    output logic [4:0]       flag_mask,
    output logic             err
);

    localparam logic [CNT_W-1:0] STEP_LIM = CNT_W'(STEP_MAX);

    logic [1:0]       state;
    logic [2:0]       op_q;
    logic             byte_q;
    logic             msb_q;
    logic [15:0]      acc;
    logic [CNT_W-1:0] rem;

    logic [CNT_W-1:0] k_full;
    logic [CNT_W-1:0] rem_next;
    logic [15:0]      step_res;
    logic             step_cout;
    logic [15:0]      acc_in;
    logic             res_msb;
    logic             res_msb1;
    logic             res_zero;
    logic             of_bit;
    logic             is_rot;
    logic [4:0]       new_flags;
    logic [4:0]       new_mask;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    assign k_full   = (rem < STEP_LIM) ? rem : STEP_LIM;
    assign rem_next = rem - k_full;
    assign acc_in   = is_byte ? {8'h00, a[7:0]} : a;

    shift_step_16 u_step (
        .acc     (acc),
        .k       (4'(k_full)),
        .op      (op_q),
        .is_byte (byte_q),
        .res     (step_res),
        .cout    (step_cout)
    );

    // Flags are derived from the final step's output so they are ready in
    // the same cycle the result is captured.
    always_comb begin
        res_msb  = byte_q ? step_res[7] : step_res[15];
        res_msb1 = byte_q ? step_res[6] : step_res[14];
        res_zero = byte_q ? (step_res[7:0] == 8'h00) : (step_res == 16'h0000);
        is_rot   = (op_q == OP_ROL) || (op_q == OP_ROR);
        case (op_q)
            OP_SHL, OP_ROL: of_bit = res_msb ^ step_cout;
            OP_SHR:         of_bit = msb_q;
            OP_ROR:         of_bit = res_msb ^ res_msb1;
            default:        of_bit = 1'b0;
        endcase
        new_mask         = is_rot ? MASK_ROTATE : MASK_ALL;
        new_flags        = 5'h00;
        new_flags[F_CF]  = step_cout;
        new_flags[F_OF]  = of_bit;
        new_flags[F_PF]  = ~^step_res[7:0];
        new_flags[F_ZF]  = res_zero;
        new_flags[F_SF]  = res_msb;
        new_flags        = new_flags & new_mask;
    end

    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            state     <= ST_IDLE;
            op_q      <= OP_SHL;
            byte_q    <= 1'b0;
            msb_q     <= 1'b0;
            acc       <= 16'h0000;
            rem       <= '0;
            r         <= 16'h0000;
            flags     <= 5'h00;
            flag_mask <= 5'h00;
            err       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q      <= op;
                        byte_q    <= is_byte;
                        msb_q     <= is_byte ? a[7] : a[15];
                        acc       <= acc_in;
                        rem       <= count;
                        flags     <= 5'h00;
                        flag_mask <= 5'h00;
                        err       <= 1'b0;
                        if (!op_is_legal(op)) begin
                            r     <= a;
                            err   <= 1'b1;
                            state <= ST_DONE;
                        end else if (count == '0) begin
                            r     <= acc_in;
                            state <= ST_DONE;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    acc <= step_res;
                    rem <= rem_next;
                    if (rem_next == '0) begin
                        r         <= step_res;
                        flags     <= new_flags;
                        flag_mask <= new_mask;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Directed bench for alu_shift_sequencer: hand-computed vectors covering
// shifts, rotates, zero count, illegal op, output back-pressure and reset.
module tb_alu_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic        is_byte;
    logic [15:0] a;
    logic [7:0]  count;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] r;
    logic [4:0]  flags;
    logic [4:0]  flag_mask;
    logic        err;

    int n_checks = 0;
    int n_fails  = 0;
    int lat;

    alu_shift_sequencer #(.STEP_MAX(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .is_byte   (is_byte),
        .a         (a),
        .count     (count),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .flags     (flags),
        .flag_mask (flag_mask),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request; lat = edges from the accepting edge until out_valid (1 + RUN cycles).
    task automatic send(input logic [2:0] o, input logic b, input logic [15:0] av,
                        input logic [7:0] c, output int l);
        @(negedge clk);
        check("in_ready_before_req", 32'(in_ready), 32'd1);
        in_valid = 1'b1; op = o; is_byte = b; a = av; count = c;
        @(posedge clk); #1;
        in_valid = 1'b0;
        l = 1;
        while (!out_valid && l < 300) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_after_release", 32'(out_valid), 32'd0);
        check("in_ready_after_release", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; op = 3'b000; is_byte = 1'b0;
        a = 16'h0000; count = 8'h00; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_r", 32'(r), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_mask", 32'(flag_mask), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(negedge clk); rst = 1'b0;

        // 1: SHR word 0x8001 >> 1
        send(3'b001, 1'b0, 16'h8001, 8'd1, lat);
        check("t1_lat", 32'(lat), 32'd2);
        check("t1_r", 32'(r), 32'h4000);
        check("t1_flags", 32'(flags), 32'h13);
        check("t1_mask", 32'(flag_mask), 32'h1F);
        check("t1_err", 32'(err), 32'd0);
        release_out();

        // 2: SAR word 0x8000 by 20 (steps 8,8,4)
        send(3'b010, 1'b0, 16'h8000, 8'd20, lat);
        check("t2_lat", 32'(lat), 32'd4);
        check("t2_r", 32'(r), 32'hFFFF);
        check("t2_flags", 32'(flags), 32'h0B);
        check("t2_mask", 32'(flag_mask), 32'h1F);
        release_out();

        // 3: ROL byte 0x81 by 9
        send(3'b011, 1'b1, 16'h0081, 8'd9, lat);
        check("t3_lat", 32'(lat), 32'd3);
        check("t3_r", 32'(r), 32'h0003);
        check("t3_mask", 32'(flag_mask), 32'h11);
        check("t3_flags_masked", 32'(flags & flag_mask), 32'h11);
        release_out();

        // ROR word 0x0001 by 1
        send(3'b100, 1'b0, 16'h0001, 8'd1, lat);
        check("ror_r", 32'(r), 32'h8000);
        check("ror_flags_masked", 32'(flags & flag_mask), 32'h11);
        release_out();

        // 5: SHR byte 0xF0 by 8, then hold the result under back-pressure
        send(3'b001, 1'b1, 16'h00F0, 8'd8, lat);
        check("t5_lat", 32'(lat), 32'd2);
        check("t5_r", 32'(r), 32'h0000);
        check("t5_flags", 32'(flags), 32'h17);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("t5_hold_valid", 32'(out_valid), 32'd1);
            check("t5_hold_in_ready", 32'(in_ready), 32'd0);
            check("t5_hold_r", 32'(r), 32'h0000);
            check("t5_hold_flags", 32'(flags), 32'h17);
        end
        release_out();

        // 4: zero count passes the operand through; illegal op flags err
        send(3'b000, 1'b0, 16'h1234, 8'd0, lat);
        check("t4_lat", 32'(lat), 32'd1);
        check("t4_r", 32'(r), 32'h1234);
        check("t4_mask", 32'(flag_mask), 32'h00);
        check("t4_err", 32'(err), 32'd0);
        release_out();
        send(3'b110, 1'b0, 16'hABCD, 8'd3, lat);
        check("t4_illegal_lat", 32'(lat), 32'd1);
        check("t4_illegal_err", 32'(err), 32'd1);
        check("t4_illegal_r", 32'(r), 32'hABCD);
        check("t4_illegal_mask", 32'(flag_mask), 32'h00);
        release_out();

        // 6: reset during the 10th RUN cycle of a 255-bit SHL
        @(negedge clk);
        in_valid = 1'b1; op = 3'b000; is_byte = 1'b0; a = 16'hFFFF; count = 8'd255;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("t6_running", 32'(in_ready), 32'd0);
        repeat (9) @(posedge clk);
        #1;
        check("t6_still_running", 32'(out_valid), 32'd0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("t6_rst_out_valid", 32'(out_valid), 32'd0);
        check("t6_rst_in_ready", 32'(in_ready), 32'd1);
        check("t6_rst_r", 32'(r), 32'd0);
        check("t6_rst_err", 32'(err), 32'd0);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t6_no_output", 32'(out_valid), 32'd0);

        // SHL word 0x0001 by 15 after reset (steps 8,7)
        send(3'b000, 1'b0, 16'h0001, 8'd15, lat);
        check("t6_new_lat", 32'(lat), 32'd3);
        check("t6_new_r", 32'(r), 32'h8000);
        check("t6_new_flags", 32'(flags), 32'h1A);
        check("t6_new_mask", 32'(flag_mask), 32'h1F);
        release_out();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
